// File: rtl/stair_light_ctrl.sv
// rtl/stair_light_ctrl.sv - staircase-switch LED pattern controller
// Two debounced switches toggle a rotating LED run; a button pauses it; a step timeout ends it.
module stair_light_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_CYCLES     = 5000000,
  parameter int TIMEOUT_STEPS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  sw,
  input  logic        btn,
  output logic [15:0] ledr
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW      = $clog2(STEP_CYCLES);
  localparam int STW     = (TIMEOUT_STEPS == 0) ? 1 : $clog2(TIMEOUT_STEPS + 1);
  localparam int TO_LAST = (TIMEOUT_STEPS == 0) ? 0 : TIMEOUT_STEPS - 1;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db_q, db_d;
  logic [DBW-1:0] dcnt_q [3];
  logic [DBW-1:0] dcnt_d [3];
  logic           xor_q, xor_d;
  logic           btnp_q, btnp_d;
  state_t         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [STW-1:0] steps_q, steps_d;
  logic [7:0]     pattern_q, pattern_d;

  logic           toggle, press, tc, timeout_hit, lamp;
  logic [STW+3:0] steps_ext;

  assign raw = {btn, sw};

  // Each input flips its debounced level only after DEBOUNCE_CYCLES unbroken disagreeing samples.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_d[i]   = db_q[i];
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    toggle      = ((db_q[0] ^ db_q[1]) != xor_q);
    press       = db_q[2] & ~btnp_q;
    tc          = (state_q == RUN) && (presc_q == PW'(STEP_CYCLES - 1));
    timeout_hit = (TIMEOUT_STEPS != 0) && (steps_q == STW'(TO_LAST));

    xor_d     = db_q[0] ^ db_q[1];
    btnp_d    = db_q[2];
    state_d   = state_q;
    presc_d   = presc_q;
    steps_d   = steps_q;
    pattern_d = pattern_q;

    case (state_q)
      OFF: begin
        if (toggle) begin
          state_d   = RUN;
          presc_d   = '0;
          steps_d   = '0;
          pattern_d = 8'h01;
        end
      end
      RUN: begin
        if (toggle) begin
          state_d = OFF;
        end else if (press) begin
          state_d = PAUSE;
        end else if (tc) begin
          if (timeout_hit) begin
            state_d = OFF;
          end else begin
            pattern_d = {pattern_q[6:0], pattern_q[7]};
            presc_d   = '0;
            if (steps_q != '1) begin
              steps_d = steps_q + STW'(1);
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (toggle) begin
          state_d = OFF;
        end else if (press) begin
          state_d = RUN;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
      xor_q     <= 1'b0;
      btnp_q    <= 1'b0;
      state_q   <= OFF;
      presc_q   <= '0;
      steps_q   <= '0;
      pattern_q <= 8'h01;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= dcnt_d[i];
      xor_q     <= xor_d;
      btnp_q    <= btnp_d;
      state_q   <= state_d;
      presc_q   <= presc_d;
      steps_q   <= steps_d;
      pattern_q <= pattern_d;
    end
  end

  assign lamp      = (state_q != OFF);
  assign steps_ext = {4'b0000, steps_q};

  always_comb begin
    ledr        = '0;
    ledr[7:0]   = lamp ? pattern_q : 8'h00;
    ledr[8]     = lamp;
    ledr[9]     = (state_q == PAUSE);
    ledr[11:10] = db_q[1:0];
    ledr[15:12] = lamp ? steps_ext[3:0] : 4'h0;
  end

endmodule

// File: tb/tb_stair_light_ctrl.sv
// tb/tb_stair_light_ctrl.sv - directed-vector bench for stair_light_ctrl
// Timeline comments count posedges relative to the most recent lamp turn-on.
module tb_stair_light_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  sw;
  logic        btn;
  logic [15:0] ledr;

  int n_vec;
  int n_miss;

  stair_light_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8),
    .TIMEOUT_STEPS  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .btn (btn),
    .ledr(ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: ledr=%h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b0;
    sw     = 2'b00;
    btn    = 1'b0;
    cyc(3);
    check("reset_state", ledr, 16'h0000);
    rst = 1'b1;

    // Pulses shorter than the debounce window never reach db_sw.
    for (int i = 0; i < 3; i++) begin
      sw = 2'b01;
      cyc(3);
      check("glitch_hi", ledr, 16'h0000);
      sw = 2'b00;
      cyc(5);
      check("glitch_lo", ledr, 16'h0000);
    end

    sw = 2'b01;
    cyc(6);
    check("db_sw_rise", ledr, 16'h0400);
    cyc(1);
    check("run_entry", ledr, 16'h0501);
    cyc(7);
    check("pre_step1", ledr, 16'h0501);
    cyc(1);
    check("step1", ledr, 16'h1502);
    cyc(8);
    check("step2", ledr, 16'h2504);
    cyc(8);
    check("step3", ledr, 16'h3508);
    cyc(7);
    check("pre_timeout", ledr, 16'h3508);
    cyc(1);
    check("timeout_off", ledr, 16'h0400);
    cyc(10);
    check("stay_off", ledr, 16'h0400);

    sw = 2'b11;
    cyc(6);
    check("db_sw1_rise", ledr, 16'h0C00);
    cyc(1);
    check("relight", ledr, 16'h0D01);           // E

    cyc(5);
    btn = 1'b1;                                 // E+5
    cyc(3);
    check("rot_before_pause", ledr, 16'h1D02);  // E+8
    cyc(3);
    check("press_cycle", ledr, 16'h1D02);       // E+11
    cyc(1);
    check("pause_entry", ledr, 16'h1F02);       // E+12
    cyc(3);
    btn = 1'b0;                                 // E+15
    for (int i = 0; i < 5; i++) begin
      cyc(20);
      check("pause_hold", ledr, 16'h1F02);
    end
    btn = 1'b1;                                 // E+115
    cyc(6);
    check("pause_pre_resume", ledr, 16'h1F02);  // E+121
    cyc(1);
    check("resume", ledr, 16'h1D02);            // E+122
    btn = 1'b0;
    cyc(4);
    check("resume_pre_rot", ledr, 16'h1D02);    // E+126
    cyc(1);
    check("resume_rot", ledr, 16'h2D04);        // E+127

    sw = 2'b00;
    cyc(5);
    check("dual_flip_pre", ledr, 16'h2D04);     // E+132
    cyc(1);
    check("dual_flip_db", ledr, 16'h2104);      // E+133
    cyc(1);
    check("dual_flip_no_toggle", ledr, 16'h2104);
    sw = 2'b01;                                 // E+134
    cyc(1);
    check("run_step3", ledr, 16'h3108);
    cyc(5);
    check("toggle_pending", ledr, 16'h3508);    // E+140
    cyc(1);
    check("toggle_off", ledr, 16'h0400);        // E+141

    sw = 2'b00;
    cyc(7);
    check("run_again", ledr, 16'h0101);
    cyc(3);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", ledr, 16'h0000);
    #2;
    rst = 1'b1;
    cyc(20);
    check("off_after_reset", ledr, 16'h0000);
    sw = 2'b01;
    cyc(6);
    check("post_reset_db", ledr, 16'h0400);
    cyc(1);
    check("post_reset_relight", ledr, 16'h0501);

    rst = 1'b0;
    sw  = 2'b10;
    #1;
    check("reset_sw_high", ledr, 16'h0000);
    cyc(2);
    rst = 1'b1;
    cyc(6);
    check("held_high_db", ledr, 16'h0800);
    cyc(1);
    check("held_high_on", ledr, 16'h0901);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
